// File: rtl/bcd_converter_seq_if.sv
// Start/done handshake and result bus between a requester and the
// sequential binary-to-BCD converter.
interface bcd_converter_seq_if #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
);
    logic                           start;
    logic [BIN_WIDTH-1:0]           binary;
    logic                           busy;
    logic                           done;
    logic [4*DIGITS-1:0]            bcd;
    logic                           overflow;
    logic [$clog2(DIGITS+1)-1:0]    sig_digits;

    modport master (
        output start, binary,
        input  busy, done, bcd, overflow, sig_digits
    );

    modport slave (
        input  start, binary,
        output busy, done, bcd, overflow, sig_digits
    );
endinterface

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One bit of the
// binary value is consumed per clock; results are registered on done.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; results hold their last values
//   SHIFT | one correct-and-shift step per cycle, BIN_WIDTH steps total
module bcd_converter_seq #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_converter_seq_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam int SW = $clog2(DIGITS + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state;
    logic [BIN_WIDTH-1:0] shreg;
    logic [BW-1:0]        work;
    logic                 ovf_acc;
    logic [CW-1:0]        cnt;

    logic                 busy_r;
    logic                 done_r;
    logic [BW-1:0]        bcd_r;
    logic                 ovf_r;
    logic [SW-1:0]        sig_r;

    logic [BW-1:0]           corrected;
    logic [BW+BIN_WIDTH-1:0] shifted;
    logic [BW-1:0]           work_next;
    logic [BIN_WIDTH-1:0]    shreg_next;
    logic                    ovf_next;
    logic [SW-1:0]           sig_next;

    // Add-3 correction on every digit in parallel, then shift the whole
    // {digits, remainder} field left by one. A 1 leaving the top digit
    // means the value needs more than DIGITS digits.
    always_comb begin
        corrected = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                corrected[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
        shifted    = {corrected, shreg} << 1;
        work_next  = shifted[BW+BIN_WIDTH-1 -: BW];
        shreg_next = shifted[BIN_WIDTH-1:0];
        ovf_next   = ovf_acc | corrected[BW-1];
    end

    // Significant-digit count from the truncated digits; zero still shows one digit.
    always_comb begin
        sig_next = SW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (work_next[4*i +: 4] != 4'd0) begin
                sig_next = SW'(i + 1);
            end
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            work    <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            bcd_r   <= '0;
            ovf_r   <= 1'b0;
            sig_r   <= SW'(1);
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg   <= bus.binary;
                        work    <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg_next;
                    work    <= work_next;
                    ovf_acc <= ovf_next;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(BIN_WIDTH - 1)) begin
                        bcd_r  <= work_next;
                        ovf_r  <= ovf_next;
                        sig_r  <= sig_next;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.bcd        = bcd_r;
    assign bus.overflow   = ovf_r;
    assign bus.sig_digits = sig_r;
endmodule

// File: tb/tb_bcd_converter_seq.sv
// Scoreboard bench for bcd_converter_seq across four parameter sets:
// 0: 8/3, 1: 8/2, 2: 5/2, 3: 16/5.
module tb_bcd_converter_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        start_v [4];
    logic [15:0] bin_v   [4];
    logic        done_v  [4];
    logic        busy_v  [4];
    logic        ovf_v   [4];
    logic [19:0] bcd_v   [4];
    logic [3:0]  sig_v   [4];
    int          dn      [4];

    typedef struct packed {
        logic [19:0] bcd;
        logic        ovf;
        logic [3:0]  sig;
    } exp_t;

    exp_t q0[$], q1[$], q2[$], q3[$];

    bcd_converter_seq_if #(.BIN_WIDTH(8),  .DIGITS(3)) ia ();
    bcd_converter_seq_if #(.BIN_WIDTH(8),  .DIGITS(2)) ib ();
    bcd_converter_seq_if #(.BIN_WIDTH(5),  .DIGITS(2)) ic ();
    bcd_converter_seq_if #(.BIN_WIDTH(16), .DIGITS(5)) id ();

    bcd_converter_seq #(.BIN_WIDTH(8),  .DIGITS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    bcd_converter_seq #(.BIN_WIDTH(8),  .DIGITS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    bcd_converter_seq #(.BIN_WIDTH(5),  .DIGITS(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));
    bcd_converter_seq #(.BIN_WIDTH(16), .DIGITS(5)) dut_d (.clk(clk), .rst_n(rst_n), .bus(id));

    assign ia.start = start_v[0];  assign ia.binary = bin_v[0][7:0];
    assign ib.start = start_v[1];  assign ib.binary = bin_v[1][7:0];
    assign ic.start = start_v[2];  assign ic.binary = bin_v[2][4:0];
    assign id.start = start_v[3];  assign id.binary = bin_v[3];

    assign done_v[0] = ia.done;  assign busy_v[0] = ia.busy;  assign ovf_v[0] = ia.overflow;
    assign done_v[1] = ib.done;  assign busy_v[1] = ib.busy;  assign ovf_v[1] = ib.overflow;
    assign done_v[2] = ic.done;  assign busy_v[2] = ic.busy;  assign ovf_v[2] = ic.overflow;
    assign done_v[3] = id.done;  assign busy_v[3] = id.busy;  assign ovf_v[3] = id.overflow;
    assign bcd_v[0] = 20'(ia.bcd);  assign sig_v[0] = 4'(ia.sig_digits);
    assign bcd_v[1] = 20'(ib.bcd);  assign sig_v[1] = 4'(ib.sig_digits);
    assign bcd_v[2] = 20'(ic.bcd);  assign sig_v[2] = 4'(ic.sig_digits);
    assign bcd_v[3] = 20'(id.bcd);  assign sig_v[3] = 4'(id.sig_digits);

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, want);
        end
    endtask

    // Reference model: decimal digits by repeated division.
    function automatic logic [19:0] m_bcd(int unsigned v, int d);
        logic [19:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] m_sig(logic [19:0] b, int d);
        logic [3:0] s = 4'd1;
        for (int i = 0; i < d; i++) begin
            if (b[4*i +: 4] != 4'd0) s = 4'(i + 1);
        end
        return s;
    endfunction

    task automatic push(int w, logic [19:0] eb, logic eo, logic [3:0] es);
        exp_t e;
        e.bcd = eb; e.ovf = eo; e.sig = es;
        case (w)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic mon(int w);
        exp_t e;
        logic got;
        got = 1'b1;
        e = '0;
        dn[w]++;
        case (w)
            0: if (q0.size() > 0) e = q0.pop_front(); else got = 1'b0;
            1: if (q1.size() > 0) e = q1.pop_front(); else got = 1'b0;
            2: if (q2.size() > 0) e = q2.pop_front(); else got = 1'b0;
            default: if (q3.size() > 0) e = q3.pop_front(); else got = 1'b0;
        endcase
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done inst=%0d actual=done expected=no_done", w);
        end else begin
            chk($sformatf("bcd[%0d]", w), 32'(bcd_v[w]), 32'(e.bcd));
            chk($sformatf("overflow[%0d]", w), 32'(ovf_v[w]), 32'(e.ovf));
            chk($sformatf("sig_digits[%0d]", w), 32'(sig_v[w]), 32'(e.sig));
        end
    endtask

    // Monitor: every done pulse is checked against the scoreboard.
    always @(negedge clk) begin
        for (int w = 0; w < 4; w++) begin
            if (done_v[w] === 1'b1) mon(w);
        end
    end

    // One accepted conversion; binary is scrambled right after the accept edge,
    // and an optional start pulse is injected while busy.
    task automatic convert(int w, logic [15:0] bin, logic [19:0] eb, logic eo,
                           logic [3:0] es, int lat_exp, int pulse_at);
        int lat;
        push(w, eb, eo, es);
        @(negedge clk);
        start_v[w] = 1'b1;
        bin_v[w]   = bin;
        @(negedge clk);
        start_v[w] = 1'b0;
        bin_v[w]   = ~bin;
        chk("busy_after_accept", 32'(busy_v[w]), 32'd1);
        lat = 0;
        while (done_v[w] !== 1'b1 && lat < 40) begin
            start_v[w] = (lat == pulse_at);
            if (lat == pulse_at) bin_v[w] = 16'h0000;
            @(negedge clk);
            lat++;
        end
        start_v[w] = 1'b0;
        chk("latency", 32'(lat), 32'(lat_exp));
        chk("busy_at_done", 32'(busy_v[w]), 32'd0);
    endtask

    initial begin
        int t [3];
        int nd;
        int c;
        int dn_before;
        int unsigned v;
        logic [19:0] eb;

        for (int w = 0; w < 4; w++) begin
            start_v[w] = 1'b0;
            bin_v[w]   = 16'h0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        for (int w = 0; w < 4; w++) begin
            chk("reset_busy", 32'(busy_v[w]), 32'd0);
            chk("reset_done", 32'(done_v[w]), 32'd0);
            chk("reset_bcd", 32'(bcd_v[w]), 32'd0);
            chk("reset_overflow", 32'(ovf_v[w]), 32'd0);
            chk("reset_sig", 32'(sig_v[w]), 32'd1);
        end
        rst_n = 1'b1;

        // Defaults 8/3
        convert(0, 16'd0,   20'h000, 1'b0, 4'd1, 8, -1);
        convert(0, 16'd255, 20'h255, 1'b0, 4'd3, 8, 2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bin_v[0] = 16'($urandom_range(0, 255));
            chk("bcd_hold", 32'(bcd_v[0]), 32'h255);
        end
        convert(0, 16'd31,  20'h031, 1'b0, 4'd2, 8, -1);

        // start held high: one conversion every 9 cycles
        for (int k = 0; k < 3; k++) push(0, 20'h031, 1'b0, 4'd2);
        @(negedge clk);
        start_v[0] = 1'b1;
        bin_v[0]   = 16'd31;
        nd = 0;
        c  = 0;
        while (nd < 3 && c < 60) begin
            @(negedge clk);
            c++;
            if (done_v[0] === 1'b1) begin
                t[nd] = c;
                nd++;
                if (nd == 3) start_v[0] = 1'b0;
            end
        end
        start_v[0] = 1'b0;
        chk("continuous_done_count", 32'(nd), 32'd3);
        if (nd == 3) begin
            chk("continuous_first", 32'(t[0]), 32'd9);
            chk("continuous_gap1", 32'(t[1] - t[0]), 32'd9);
            chk("continuous_gap2", 32'(t[2] - t[1]), 32'd9);
        end

        // Reset four cycles after accept aborts the conversion
        repeat (2) @(negedge clk);
        dn_before = dn[0];
        start_v[0] = 1'b1;
        bin_v[0]   = 16'd200;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy_v[0]), 32'd0);
        chk("abort_done", 32'(done_v[0]), 32'd0);
        chk("abort_bcd", 32'(bcd_v[0]), 32'd0);
        chk("abort_sig", 32'(sig_v[0]), 32'd1);
        chk("abort_overflow", 32'(ovf_v[0]), 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 32'(dn[0] - dn_before), 32'd0);
        convert(0, 16'd128, 20'h128, 1'b0, 4'd3, 8, -1);

        // 8/2 truncation and overflow
        convert(1, 16'd255, 20'h55, 1'b1, 4'd2, 8, -1);
        convert(1, 16'd99,  20'h99, 1'b0, 4'd2, 8, -1);
        convert(1, 16'd100, 20'h00, 1'b1, 4'd1, 8, -1);
        convert(1, 16'd9,   20'h09, 1'b0, 4'd1, 8, -1);

        // 5/2 exhaustive
        for (int k = 0; k < 32; k++) begin
            eb = m_bcd(k, 2);
            convert(2, 16'(k), eb, 1'b0, m_sig(eb, 2), 5, -1);
        end

        // 16/5 boundaries then random
        for (int k = 0; k < 1004; k++) begin
            case (k)
                0: v = 0;
                1: v = 65535;
                2: v = 10000;
                3: v = 9999;
                default: v = $urandom_range(0, 65535);
            endcase
            eb = m_bcd(v, 5);
            convert(3, 16'(v), eb, (v >= 100000), m_sig(eb, 5), 16, -1);
        end

        repeat (4) @(negedge clk);
        chk("done_count_a", 32'(dn[0]), 32'd7);
        chk("done_count_b", 32'(dn[1]), 32'd4);
        chk("done_count_c", 32'(dn[2]), 32'd32);
        chk("done_count_d", 32'(dn[3]), 32'd1004);
        chk("scoreboard_empty", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
